// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: FSM state encoding, 50 MHz default timing and helpers.
// Also imported by the I2C pixel front end.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } ws_state_t;

  localparam int unsigned DEF_T0H        = 20;
  localparam int unsigned DEF_T1H        = 40;
  localparam int unsigned DEF_T_BIT      = 62;
  localparam int unsigned DEF_RES_CYCLES = 2500;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned IDX_W   = $clog2(PIXEL_W);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single-bit WS2812 waveform generator: high for T0H/T1H cycles, then low to T_BIT.
// A start on the final cycle of a bit chains the next bit without a gap.
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H   = DEF_T0H,
  parameter int unsigned T1H   = DEF_T1H,
  parameter int unsigned T_BIT = DEF_T_BIT,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_i,
  input  logic start_i,
  output logic led_o,
  output logic done_o
);

  logic             r_active;
  logic             r_bit;
  logic             r_led;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_thr;
  logic             w_last_cycle;

  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_thr        = r_bit ? CNT_W'(T1H) : CNT_W'(T0H);
  assign w_last_cycle = (r_cnt == CNT_W'(T_BIT - 1));
  assign done_o       = r_active && w_last_cycle;
  assign led_o        = r_led;

  // led is registered from the next counter value so the line changes exactly on a clock edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_bit    <= 1'b0;
      r_led    <= 1'b0;
      r_cnt    <= '0;
    end else if (start_i) begin
      r_active <= 1'b1;
      r_bit    <= bit_i;
      r_led    <= 1'b1;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (w_last_cycle) begin
        r_active <= 1'b0;
        r_led    <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
        r_led <= (w_cnt_inc < w_thr);
      end
    end else begin
      r_led <= 1'b0;
    end
  end

endmodule

// File: rtl/ws2812_driver.sv
// WS2812 pixel driver: accepts 24-bit GRB words, shifts them out MSB first,
// and inserts the latch gap after the last pixel of a frame.
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H        = DEF_T0H,
  parameter int unsigned T1H        = DEF_T1H,
  parameter int unsigned T_BIT      = DEF_T_BIT,
  parameter int unsigned RES_CYCLES = DEF_RES_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIXEL_W-1:0] pixel_i,
  input  logic               valid_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               led_o
);

  localparam int unsigned CW = $clog2(max_u(T_BIT, RES_CYCLES) + 1);

  ws_state_t          r_state;
  logic [PIXEL_W-2:0] r_shift;
  logic               r_last;
  logic [IDX_W-1:0]   r_idx;
  logic [CW-1:0]      r_gap;
  logic               r_ready;
  logic               r_busy;

  logic               w_accept;
  logic               w_start;
  logic               w_bit;
  logic               w_done;
  logic               w_led;

  assign w_accept = (r_state == ST_IDLE) && valid_i;
  // Bit 23 goes straight to the bit generator; the shifter only holds bits 22..0
  assign w_start  = w_accept || ((r_state == ST_SEND) && w_done && (r_idx != '0));
  assign w_bit    = (r_state == ST_IDLE) ? pixel_i[PIXEL_W-1] : r_shift[PIXEL_W-2];

  ws2812_bit_tx #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT),
    .CNT_W (CW)
  ) u_bit_tx (
    .clk     (clk),
    .reset   (reset),
    .bit_i   (w_bit),
    .start_i (w_start),
    .led_o   (w_led),
    .done_o  (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            r_state <= ST_SEND;
            r_shift <= pixel_i[PIXEL_W-2:0];
            r_last  <= last_i;
            r_idx   <= IDX_W'(PIXEL_W - 1);
            r_gap   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_done) begin
            if (r_idx == '0) begin
              if (r_last) begin
                r_state <= ST_LATCH;
                r_gap   <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else begin
              r_idx   <= r_idx - IDX_W'(1);
              r_shift <= {r_shift[PIXEL_W-3:0], 1'b0};
            end
          end
        end
        ST_LATCH: begin
          if (r_gap == CW'(RES_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign led_o   = w_led;

endmodule

// File: doc/ws2812_driver.md
WS2812_DRIVER -- requirements
Module: ws2812_driver

Interface
REQ-001 Parameter T0H, default 20, high time of a '0' bit in clk cycles.
REQ-002 Parameter T1H, default 40, high time of a '1' bit in clk cycles.
REQ-003 Parameter T_BIT, default 62, total bit period in clk cycles.
REQ-004 Parameter RES_CYCLES, default 2500, low time of the latch/reset gap in clk cycles.
REQ-005 clk  input  1  single clock; all logic is on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pixel_i  input  24  colour word in GRB order, MSB (G[7]) sent first.
REQ-008 valid_i  input  1  pixel_i and last_i are valid.
REQ-009 last_i  input  1  pixel_i is the final pixel of a frame; the latch gap follows it.
REQ-010 ready_o  output  1  the block accepts a pixel this cycle.
REQ-011 busy_o  output  1  a pixel or latch gap is in progress.
REQ-012 led_o  output  1  WS2812 serial data line.

Function
REQ-013 States: IDLE, SEND, LATCH.
REQ-014 ready_o SHALL be 1 only in IDLE; a pixel is accepted when valid_i && ready_o on a rising edge.
REQ-015 On accept, pixel_i and last_i SHALL be registered; later changes on the inputs have no effect on the pixel in flight.
REQ-016 Accept SHALL move the block to SEND, with bit index 23 and cycle counter 0.
REQ-017 In SEND, led_o SHALL be 1 while cycle counter < (bit ? T1H : T0H), and 0 otherwise, for T_BIT cycles per bit.
REQ-018 The first led_o high SHALL occur the cycle after accept, giving 1-cycle latency.
REQ-019 After bit 0 completes its T_BIT cycles:
  - if last was set, go to LATCH;
  - otherwise go to IDLE.
REQ-020 In LATCH, led_o SHALL be held 0 for RES_CYCLES cycles, after which the block enters IDLE.
REQ-021 In IDLE, led_o SHALL be 0.
REQ-022 A pixel with last_i=0 returning through IDLE SHALL add exactly 1 low cycle before the next pixel if valid_i is already high; this must stay well below RES_CYCLES.
REQ-023 valid_i during SEND or LATCH SHALL be ignored, with no accept and no state change.
REQ-024 busy_o SHALL be 1 in SEND and LATCH, and 0 in IDLE.
REQ-025 The cycle counter SHALL be $clog2(max(T_BIT,RES_CYCLES)+1) bits wide and SHALL never wrap within a bit or gap.
REQ-026 Legal parameters: 0 < T0H < T1H < T_BIT, and RES_CYCLES >= 1; other values are unsupported.

Reset
REQ-027 While reset is high at a rising edge, the block SHALL enter IDLE with led_o=0, ready_o=1 from the following cycle, busy_o=0, and counters and the captured pixel cleared.
REQ-028 Reset during SEND or LATCH SHALL abort the transfer immediately, with no completion of the current bit.
REQ-029 A pixel presented in the same cycle as reset SHALL NOT be accepted.

Structure
REQ-030 State encodings and default timing constants (T0H, T1H, T_BIT, RES_CYCLES for 50 MHz) SHALL live in a shared include/package ws2812_pkg, also used by the I2C front end.
REQ-031 An optional sub-module ws2812_bit_tx (one bit: bit_i, start_i, led_o, done_o) MAY hold the per-bit timing; the FSM and shift register stay in ws2812_driver.
REQ-032 The upstream I2C receiver SHALL drive pixel_i/valid_i/last_i directly, asserting last_i on the LED_CNT-th pixel.

Verification (T0H=2, T1H=4, T_BIT=6, RES_CYCLES=10)
REQ-033 Reset, then valid_i=1, pixel_i=24'h800001, last_i=1 -> bit 23 high for 4 cycles, bits 22..1 high for 2 cycles each, bit 0 high for 4; total 144 cycles, then 10 low cycles, then ready_o=1.
REQ-034 Three back-to-back pixels 24'hFFFFFF, 24'h000000, 24'hA5A5A5 with last_i only on the third -> 3x144 bit cycles plus 2 single idle gaps, exactly one latch gap, and decoded bits match the inputs.
REQ-035 valid_i held high with changing pixel_i during SEND -> no second accept, ready_o=0 throughout SEND and LATCH, and the transmitted word equals the value captured at accept.
REQ-036 Reset asserted mid-bit 12 of pixel 24'hFFFFFF -> led_o=0 and ready_o=1 on the cycle after the reset edge; a new pixel afterwards transmits correctly from bit 23.
REQ-037 Pixel with last_i=0 and no further valid_i -> led_o stays 0, busy_o=0, no LATCH state entered, and ready_o stays 1 indefinitely.
